// File: rtl/tile_link_arb_pkg.sv
// Shared types and the round-robin search helper for the tile link arbiter.
`include "params.svh"

package tile_link_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned MaxReq = 32;
    localparam int unsigned IdxW   = 5;

    // Unused requester bits must be zero: the search then visits ptr+1 .. MaxReq-1, 0 .. ptr,
    // which matches the modulo-NUM_REQ order for any NUM_REQ up to MaxReq.
    function automatic logic [IdxW-1:0] rr_next(input logic [MaxReq-1:0] valid,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] idx;
        rr_next = '0;
        for (int k = MaxReq; k >= 1; k--) begin
            idx = ptr + IdxW'(k);
            if (valid[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/params.svh
// Global datapath parameters for the tile link arbiter slice.
// DW is the flit width in bits on both the tile side and the link side.
`ifndef TILE_LINK_PARAMS_SVH
`define TILE_LINK_PARAMS_SVH
`define DW 8
`endif

// File: rtl/rr_picker.sv
// Combinational round-robin search: first valid requester after ptr, one-hot.
module rr_picker
    import tile_link_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PtrW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               any_valid_o
);

    logic [MaxReq-1:0] valid_ext;
    logic [IdxW-1:0]   win_idx;

    assign any_valid_o = |valid_i;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid_i;
        win_idx                  = rr_next(valid_ext, IdxW'(ptr_i));
        winner_o                 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_o[i] = any_valid_o && (win_idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/tile_link_arbiter.sv
// Packet-locked round-robin arbiter sharing one link among NUM_REQ tile streams.
// Optional stall watchdog enabled by defining TILE_LINK_ARB_WATCHDOG_EN.
`include "params.svh"

module tile_link_arbiter
    import tile_link_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned PKT_LEN   = 16,
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ*`DW-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [`DW-1:0]           out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic                     stall_o
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(PKT_LEN + 1);

    arb_state_e         state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    owner_q, owner_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [`DW-1:0]     out_data_q;
    logic               out_valid_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_any;
    logic [PtrW-1:0]    pick_idx;
    logic               link_free;
    logic               xfer;
    logic [`DW-1:0]     owner_data;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PtrW    (PtrW)
    ) u_picker (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .winner_o    (pick_onehot),
        .any_valid_o (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PtrW'(i);
            end
        end
    end

    // Ready never looks at req_valid_i, only at the output slot and link ready.
    assign link_free   = ~out_valid_q | out_ready_i;
    assign req_ready_o = (state_q == ARB_LOCKED && link_free) ? grant_q : '0;
    assign xfer        = |(req_valid_i & req_ready_o);
    assign owner_data  = req_data_i[owner_q*`DW +: `DW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(PKT_LEN - 1)) begin
                        ptr_d   = owner_q;
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= PtrW'(NUM_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            if (xfer) begin
                out_data_q  <= owner_data;
                out_valid_q <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == ARB_LOCKED);

`ifdef TILE_LINK_ARB_WATCHDOG_EN
    localparam int unsigned WdtW = $clog2(WDT_LIMIT + 1);

    logic [WdtW-1:0] wdt_q, wdt_d;

    always_comb begin
        wdt_d = wdt_q;
        if (out_valid_q && !out_ready_i) begin
            if (wdt_q != WdtW'(WDT_LIMIT)) begin
                wdt_d = wdt_q + 1'b1;
            end
        end else if (out_valid_q) begin
            wdt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
            if (wdt_d == WdtW'(WDT_LIMIT) && wdt_q != WdtW'(WDT_LIMIT)) begin
                $display("time %0t: link arbiter stalled, owner %0d", $time, owner_q);
            end
        end
    end

    assign stall_o = (wdt_q == WdtW'(WDT_LIMIT));
`else
    logic unused_wdt_limit;
    assign unused_wdt_limit = ^WDT_LIMIT;
    assign stall_o          = 1'b0;
`endif

endmodule
